// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 encodings, FSM states and lane/extension helpers for dmem_byte_lane
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, SPLIT_HI, RESP} state_t;
  function automatic logic f3_legal(input logic [2:0] f);
    return f inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction
  function automatic logic [3:0] f3_mask(input logic [2:0] f);
    return f[1] ? 4'hF : f[0] ? 4'h3 : 4'h1;
  endfunction
  function automatic logic f3_misaligned(input logic [2:0] f, input logic [1:0] off);
    return f[1] ? off != 2'd0 : f[0] && off[0];
  endfunction
  function automatic logic [31:0] f3_extend(input logic [2:0] f, input logic [31:0] v);
    return f[1] ? v : f[0] ? {{16{v[15] & ~f[2]}}, v[15:0]} : {{24{v[7] & ~f[2]}}, v[7:0]};
  endfunction
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: DEPTH x 32 storage with byte-enable synchronous write and synchronous read
module dmem_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          CLK,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // write enabled lanes and register the addressed word every cycle
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_byte_lane.sv
// dmem_byte_lane: byte-addressed data memory with B/H/W access; DMEM_MISALIGN_SPLIT_EN enables split misaligned access
module dmem_byte_lane
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  output logic              Ready,
  input  logic              RW,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] ADDr,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic              Valid,
  output logic              Fault
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] widx;
  logic [1:0] off, off_q;
  logic [2:0] f3_q;
  logic mis, fault, acc, rw_q, fault_q;
  logic [3:0] we;
  logic [AW-1:0] bank_addr;
  logic [31:0] wdata, rdata, ld_word;
  assign widx = ADDr >> 2;
  assign off = ADDr[1:0];
  assign mis = f3_misaligned(Funct3, off);
  assign acc = EN && Ready;
  assign Valid = state == RESP;
  assign Fault = Valid && fault_q;
  assign Dout = (Valid && !rw_q && !fault_q) ? f3_extend(f3_q, ld_word) : 32'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [7:0] be_w;
  logic [63:0] wd_w;
  logic [AW-1:0] idx_q;
  logic [3:0] be_hi_q;
  logic [31:0] wd_hi_q, lo_q;
  logic split_q;
  assign be_w = {4'b0, f3_mask(Funct3)} << off;
  assign wd_w = {32'b0, Din} << {off, 3'b000};
  assign fault = !f3_legal(Funct3) || widx > LAST || (mis && widx == LAST);
  assign Ready = !RST && state != SPLIT_HI;
  assign we = (state == SPLIT_HI) ? ((RST || !rw_q) ? 4'b0 : be_hi_q) : ((acc && RW && !fault) ? be_w[3:0] : 4'b0);
  assign wdata = (state == SPLIT_HI) ? wd_hi_q : wd_w[31:0];
  assign bank_addr = (state == SPLIT_HI) ? idx_q + AW'(1) : widx[AW-1:0];
  assign ld_word = 32'((split_q ? {rdata, lo_q} : {32'b0, rdata}) >> {off_q, 3'b000});
  // low word is accessed on the accepting edge, so a split only adds the SPLIT_HI cycle
  always_comb state_nx = acc ? ((fault || !mis) ? RESP : SPLIT_HI) : ((state == SPLIT_HI) ? RESP : IDLE);
  // hold second-word lanes/data and the low word read while the high word is accessed
  always_ff @(posedge CLK) begin
    if (acc) begin
      idx_q <= widx[AW-1:0];
      be_hi_q <= be_w[7:4];
      wd_hi_q <= wd_w[63:32];
      split_q <= mis && !fault;
    end
    if (state == SPLIT_HI) lo_q <= rdata;
  end
`else
  logic [3:0] be_w;
  logic [31:0] wd_w;
  assign be_w = f3_mask(Funct3) << off;
  assign wd_w = Din << {off, 3'b000};
  assign fault = !f3_legal(Funct3) || widx > LAST || mis;
  assign Ready = !RST;
  assign we = (acc && RW && !fault) ? be_w : 4'b0;
  assign wdata = wd_w;
  assign bank_addr = widx[AW-1:0];
  assign ld_word = rdata >> {off_q, 3'b000};
  // every accepted request answers in the following cycle
  always_comb state_nx = acc ? RESP : IDLE;
`endif
  // state register
  always_ff @(posedge CLK)
    if (RST) state <= IDLE;
    else state <= state_nx;
  // capture request attributes needed to form the response
  always_ff @(posedge CLK)
    if (acc) begin
      f3_q <= Funct3;
      off_q <= off;
      rw_q <= RW;
      fault_q <= fault;
    end
  dmem_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
    .CLK(CLK),
    .we(we),
    .addr(bank_addr),
    .wdata(wdata),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_dmem_byte_lane.sv
// tb_dmem_byte_lane: directed plus random requests against a byte-array reference model
module tb_dmem_byte_lane;
  localparam int DEPTH = 64;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  logic CLK = 1'b0, RST = 1'b1, EN = 1'b0, RW = 1'b0;
  logic [2:0] Funct3 = 3'b0;
  logic [31:0] ADDr = 32'b0, Din = 32'b0, Dout;
  logic Ready, Valid, Fault;
  logic [7:0] mm [0:DEPTH*4-1];
  int errs = 0, checks = 0;
  dmem_byte_lane #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .Ready(Ready), .RW(RW), .Funct3(Funct3),
    .ADDr(ADDr), .Din(Din), .Dout(Dout), .Valid(Valid), .Fault(Fault)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic rw, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int sz, w;
    logic legal, mis, flt;
    logic [31:0] ev;
    sz = f3[1] ? 4 : f3[0] ? 2 : 1;
    legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    w = int'(a >> 2);
    mis = (a % sz) != 0;
    flt = !legal || w >= DEPTH || (mis && (!SPLIT || w + 1 >= DEPTH));
    ev = 32'b0;
    if (!flt && !rw) begin
      for (int i = 0; i < sz; i++) ev[8*i +: 8] = mm[a+i];
      if (!f3[2] && sz < 4 && ev[8*sz-1]) ev = ev | ~((32'h1 << (8*sz)) - 1);
    end
    if (!flt && rw) for (int i = 0; i < sz; i++) mm[a+i] = d[8*i +: 8];
    chk("ready_before", {31'b0, Ready}, 32'd1);
    EN = 1'b1; RW = rw; Funct3 = f3; ADDr = a; Din = d;
    @(posedge CLK);
    #1 EN = 1'b0; RW = $urandom; Funct3 = 3'($urandom); ADDr = $urandom; Din = $urandom;
    @(negedge CLK);
    if (mis && !flt) begin
      chk("split_valid_low", {31'b0, Valid}, 32'd0);
      chk("split_ready_low", {31'b0, Ready}, 32'd0);
      chk("split_dout_zero", Dout, 32'd0);
      @(negedge CLK);
    end
    chk("valid", {31'b0, Valid}, 32'd1);
    chk("fault", {31'b0, Fault}, {31'b0, flt});
    chk($sformatf("dout a=%h f3=%0d rw=%0b", a, f3, rw), Dout, ev);
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", {31'b0, Ready}, 32'd0);
    chk("rst_valid", {31'b0, Valid}, 32'd0);
    chk("rst_fault", {31'b0, Fault}, 32'd0);
    chk("rst_dout", Dout, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst", {31'b0, Ready}, 32'd1);
    chk("idle_valid", {31'b0, Valid}, 32'd0);
    for (int i = 0; i < DEPTH; i++) req(1'b1, 3'b010, 32'(i*4), $urandom);
    req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_deadbeef", Dout, 32'hDEADBEEF);
    req(1'b1, 3'b000, 32'h11, 32'h80);
    req(1'b0, 3'b000, 32'h11, 32'h0);
    chk("lb_sign", Dout, 32'hFFFFFF80);
    req(1'b0, 3'b100, 32'h11, 32'h0);
    chk("lbu_zero", Dout, 32'h00000080);
    req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_merged", Dout, 32'hDEAD80EF);
    req(1'b1, 3'b001, 32'h12, 32'h1234);
    req(1'b0, 3'b001, 32'h12, 32'h0);
    chk("lh_1234", Dout, 32'h00001234);
    req(1'b0, 3'b011, 32'h10, 32'h0);
    chk("illegal_fault", {31'b0, Fault}, 32'd1);
    req(1'b0, 3'b010, 32'(DEPTH*4), 32'h0);
    chk("oor_fault", {31'b0, Fault}, 32'd1);
    req(1'b1, 3'b010, 32'((DEPTH-1)*4+2), 32'h5A5A5A5A);
    chk("last_split_fault", {31'b0, Fault}, 32'd1);
    req(1'b0, 3'b010, 32'((DEPTH-1)*4), 32'h0);
    req(1'b1, 3'b010, 32'h21, 32'hAABBCCDD);
    chk("split_sw_fault", {31'b0, Fault}, {31'b0, !SPLIT});
    req(1'b0, 3'b010, 32'h20, 32'h0);
    req(1'b0, 3'b010, 32'h24, 32'h0);
    req(1'b0, 3'b010, 32'h21, 32'h0);
    req(1'b0, 3'b101, 32'h23, 32'h0);
    req(1'b0, 3'b001, 32'h23, 32'h0);
    for (int n = 0; n < 400; n++)
      req(1'(($urandom % 3) == 0), 3'($urandom_range(0, 7)), 32'($urandom_range(0, DEPTH*4+15)), $urandom);
`ifdef DMEM_MISALIGN_SPLIT_EN
    EN = 1'b1; RW = 1'b1; Funct3 = 3'b010; ADDr = 32'h31; Din = 32'h11223344;
    @(posedge CLK);
    #1 EN = 1'b0;
    @(negedge CLK);
    chk("mid_split_ready", {31'b0, Ready}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_valid", {31'b0, Valid}, 32'd0);
    chk("abort_ready", {31'b0, Ready}, 32'd0);
    RST = 1'b0;
    mm[32'h31] = 8'h44; mm[32'h32] = 8'h33; mm[32'h33] = 8'h22;
    req(1'b0, 3'b010, 32'h30, 32'h0);
    req(1'b0, 3'b010, 32'h34, 32'h0);
`endif
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
